// File: rtl/proc_dmem_bridge.sv
// Bridge from the single-cycle M-stage data-memory port to a multi-cycle val/rdy bus.
// Optional macro PROC_DMEM_ALIGN_CHECK_EN: misaligned accesses complete locally with misalign_err.
//
// state | meaning
// IDLE  | no access in flight; latch a new request when dmemreq_val=1
// REQ   | busreq_val asserted with latched fields, waiting for busreq_rdy
// WAIT  | request accepted, waiting for busresp_val
// DONE  | result presented on dmemresp_rdata, M released for one cycle
module proc_dmem_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmemreq_val,
  input  logic          dmemreq_type,
  input  logic [AW-1:0] dmemreq_addr,
  input  logic [DW-1:0] dmemreq_wdata,
  output logic [DW-1:0] dmemresp_rdata,
  output logic          stall_M,
  output logic          busreq_val,
  input  logic          busreq_rdy,
  output logic          busreq_type,
  output logic [AW-1:0] busreq_addr,
  output logic [DW-1:0] busreq_wdata,
  input  logic          busresp_val,
  input  logic [DW-1:0] busresp_data,
  output logic          misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic          req_type_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          misaligned;

`ifdef PROC_DMEM_ALIGN_CHECK_EN
  logic misalign_q;
  assign misaligned   = (dmemreq_addr[1:0] != 2'b00);
  assign misalign_err = (state == DONE) & misalign_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dmemreq_val) state_nxt = misaligned ? DONE : REQ;
      REQ:  if (busreq_rdy)  state_nxt = WAIT;
      WAIT: if (busresp_val) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      req_type_q  <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef PROC_DMEM_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && dmemreq_val) begin
        req_type_q  <= dmemreq_type;
        req_addr_q  <= dmemreq_addr;
        req_wdata_q <= dmemreq_wdata;
        rdata_q     <= '0;
`ifdef PROC_DMEM_ALIGN_CHECK_EN
        misalign_q  <= misaligned;
`endif
      end
      // Stores complete with zero so the W stage never sees stale load data.
      if (state == WAIT && busresp_val)
        rdata_q <= req_type_q ? '0 : busresp_data;
    end
  end

  assign busreq_val     = (state == REQ);
  assign busreq_type    = req_type_q;
  assign busreq_addr    = req_addr_q;
  assign busreq_wdata   = req_wdata_q;
  assign stall_M        = dmemreq_val & (state != DONE);
  assign dmemresp_rdata = (state == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_proc_dmem_bridge.sv
// Self-checking bench for proc_dmem_bridge: directed scenarios plus randomized accesses
// checked against a transaction-level model of stall length, result data and bus traffic.
module tb_proc_dmem_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef PROC_DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dmemreq_val, dmemreq_type;
  logic [AW-1:0] dmemreq_addr;
  logic [DW-1:0] dmemreq_wdata, dmemresp_rdata;
  logic          stall_M, busreq_val, busreq_rdy, busreq_type;
  logic [AW-1:0] busreq_addr;
  logic [DW-1:0] busreq_wdata;
  logic          busresp_val;
  logic [DW-1:0] busresp_data;
  logic          misalign_err;

  proc_dmem_bridge #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_rdata(dmemresp_rdata), .stall_M(stall_M),
    .busreq_val(busreq_val), .busreq_rdy(busreq_rdy), .busreq_type(busreq_type),
    .busreq_addr(busreq_addr), .busreq_wdata(busreq_wdata),
    .busresp_val(busresp_val), .busresp_data(busresp_data),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          t;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
  } txn_t;

  txn_t bus_log[$];
  int   checks = 0;
  int   errors = 0;

  // results of the most recent access
  int            r_stalls, r_req, r_bad, r_mis_done, r_mis_other;
  logic [DW-1:0] r_rdata;

  // Plays both the processor and the bus for one access. The bus accepts after rdy_dly
  // refused cycles and responds resp_dly cycles after the first cycle following acceptance.
  task automatic run_access(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] w,
                            input int rdy_dly, input int resp_dly,
                            input logic [DW-1:0] bdata, input bit junk);
    int waited = 0, rwait = 0, cyc = 0;
    bit accepted = 0, responded = 0, done = 0;
    r_stalls = 0; r_req = 0; r_bad = 0; r_mis_done = 0; r_mis_other = 0; r_rdata = '0;
    @(negedge clk);
    dmemreq_val = 1'b1; dmemreq_type = t; dmemreq_addr = a; dmemreq_wdata = w;
    while (!done && cyc < 200) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (junk) begin
          dmemreq_type  = 1'($urandom);
          dmemreq_addr  = $urandom;
          dmemreq_wdata = $urandom;
        end
      end
      busreq_rdy   = busreq_val && (waited >= rdy_dly);
      busresp_val  = accepted && !responded && (rwait >= resp_dly);
      busresp_data = busresp_val ? bdata : $urandom;
      if (junk && busreq_val && !busreq_rdy) busresp_val = 1'($urandom_range(0, 1));
      #1;
      if (stall_M) r_stalls++;
      if (stall_M && dmemresp_rdata !== '0) r_bad++;
      if (busreq_val) begin
        r_req++;
        if (busreq_type !== t || busreq_addr !== a || busreq_wdata !== w) r_bad++;
      end
      if (misalign_err === 1'b1) begin
        if (!stall_M) r_mis_done++;
        else r_mis_other++;
      end
      if (!stall_M) begin
        r_rdata = dmemresp_rdata;
        done = 1;
      end
      if (busreq_val && busreq_rdy) begin
        accepted = 1;
        bus_log.push_back('{t: busreq_type, a: busreq_addr, w: busreq_wdata});
      end else if (busreq_val) begin
        waited++;
      end else if (accepted && !responded) begin
        if (busresp_val) responded = 1;
        else rwait++;
      end
      @(posedge clk);
      cyc++;
    end
    busreq_rdy = 1'b0; busresp_val = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: no DONE after %0d cycles, required completion", cyc);
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    dmemreq_val = 1'b0; busreq_rdy = 1'b0; busresp_val = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = '0; dmemreq_wdata = '0;
    busreq_rdy = 0; busresp_val = 0; busresp_data = '0;
    #12;
    checks++;
    if ({stall_M, busreq_val, busreq_type, misalign_err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000",
                         {stall_M, busreq_val, busreq_type, misalign_err});
    end
    checks++;
    if ({busreq_addr, busreq_wdata, dmemresp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required 0",
                         busreq_addr, busreq_wdata, dmemresp_rdata);
    end
    @(negedge clk); rst = 1'b1;
    go_idle(1);
  endtask

  task automatic test_load_basic();
    int n = bus_log.size();
    run_access(1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
    checks++;
    if (r_stalls != 3) begin errors++; $display("FAIL load_stalls: got %0d required 3", r_stalls); end
    checks++;
    if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h required deadbeef", r_rdata); end
    checks++;
    if (bus_log.size() != n + 1 || r_req != 1 || r_bad != 0) begin
      errors++; $display("FAIL load_bus: got txns=%0d req_cycles=%0d bad=%0d required 1 1 0",
                         bus_log.size() - n, r_req, r_bad);
    end
    go_idle(1);
  endtask

  task automatic test_store_backpressure();
    int n = bus_log.size();
    run_access(1'b1, 32'h200, 32'h12345678, 4, 0, 32'hFFFF0000, 1'b0);
    checks++;
    if (r_req != 5 || r_bad != 0) begin
      errors++; $display("FAIL store_req_hold: got cycles=%0d bad=%0d required 5 0", r_req, r_bad);
    end
    checks++;
    if (r_stalls != 7) begin errors++; $display("FAIL store_stalls: got %0d required 7", r_stalls); end
    checks++;
    if (r_rdata !== '0) begin errors++; $display("FAIL store_rdata: got %h required 0", r_rdata); end
    checks++;
    if (bus_log.size() != n + 1 || bus_log[n].t !== 1'b1 || bus_log[n].a !== 32'h200 ||
        bus_log[n].w !== 32'h12345678) begin
      errors++; $display("FAIL store_bus_txn: got %0d txns required one write 200/12345678",
                         bus_log.size() - n);
    end
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    int n = bus_log.size();
    int st[3];
    logic [DW-1:0] rd[3];
    logic [AW-1:0] ad[3] = '{32'h10, 32'h14, 32'h18};
    logic          ty[3] = '{1'b0, 1'b1, 1'b0};
    logic [DW-1:0] bd[3] = '{32'hA5A5_0010, 32'h0, 32'h5A5A_0018};
    for (int i = 0; i < 3; i++) begin
      run_access(ty[i], ad[i], 32'h7700 + i, 0, 0, bd[i], 1'b0);
      st[i] = r_stalls; rd[i] = r_rdata;
    end
    checks++;
    if (bus_log.size() != n + 3) begin
      errors++; $display("FAIL b2b_count: got %0d required 3", bus_log.size() - n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bus_log[n+i].a !== ad[i] || bus_log[n+i].t !== ty[i] || st[i] != 3 ||
            rd[i] !== (ty[i] ? '0 : bd[i])) begin
          errors++; $display("FAIL b2b_txn%0d: got addr=%h type=%b stalls=%0d rdata=%h required %h %b 3 %h",
                             i, bus_log[n+i].a, bus_log[n+i].t, st[i], rd[i], ad[i], ty[i],
                             ty[i] ? '0 : bd[i]);
        end
      end
    end
    go_idle(1);
  endtask

  task automatic test_reset_mid();
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h300; dmemreq_wdata = '0;
    busreq_rdy = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    busreq_rdy = 1'b0;
    #2 rst = 1'b0; dmemreq_val = 1'b0;
    #1;
    checks++;
    if ({stall_M, busreq_val, misalign_err} !== 3'b0 || busreq_addr !== '0 || dmemresp_rdata !== '0) begin
      errors++; $display("FAIL reset_mid: got stall=%b val=%b addr=%h rdata=%h required all 0",
                         stall_M, busreq_val, busreq_addr, dmemresp_rdata);
    end
    #1 rst = 1'b1;
    run_access(1'b0, 32'h304, 32'h0, 1, 1, 32'hC0FFEE01, 1'b0);
    checks++;
    if (r_rdata !== 32'hC0FFEE01 || r_stalls != 5) begin
      errors++; $display("FAIL reset_recover: got rdata=%h stalls=%0d required c0ffee01 5", r_rdata, r_stalls);
    end
    go_idle(1);
  endtask

  task automatic test_misaligned();
    int n = bus_log.size();
    run_access(1'b0, 32'h102, 32'h0, 0, 0, 32'h1111_2222, 1'b0);
    checks++;
    if (ALIGN_CHK) begin
      if (r_stalls != 1 || r_req != 0 || bus_log.size() != n || r_mis_done != 1 ||
          r_mis_other != 0 || r_rdata !== '0) begin
        errors++; $display("FAIL misalign_on: got stalls=%0d req=%0d err_done=%0d err_other=%0d rdata=%h required 1 0 1 0 0",
                           r_stalls, r_req, r_mis_done, r_mis_other, r_rdata);
      end
    end else begin
      if (r_stalls != 3 || r_req != 1 || r_bad != 0 || r_mis_done + r_mis_other != 0 ||
          r_rdata !== 32'h1111_2222) begin
        errors++; $display("FAIL misalign_off: got stalls=%0d req=%0d err=%0d rdata=%h required 3 1 0 11112222",
                           r_stalls, r_req, r_mis_done + r_mis_other, r_rdata);
      end
    end
    go_idle(1);
  endtask

  task automatic test_spurious_resp();
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      busresp_val = 1'b1; busresp_data = $urandom;
      #1;
      if (busreq_val !== 1'b0 || stall_M !== 1'b0 || dmemresp_rdata !== '0) bad++;
    end
    busresp_val = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL spurious_idle: got %0d bad cycles required 0", bad); end
    run_access(1'b0, 32'h400, 32'h0, 3, 2, 32'h0BADF00D, 1'b1);
    checks++;
    if (r_stalls != 8 || r_rdata !== 32'h0BADF00D || r_bad != 0) begin
      errors++; $display("FAIL spurious_req: got stalls=%0d rdata=%h bad=%0d required 8 0badf00d 0",
                         r_stalls, r_rdata, r_bad);
    end
    go_idle(1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 25; i++) begin
      logic          t  = 1'($urandom);
      logic [AW-1:0] a  = $urandom;
      logic [DW-1:0] w  = $urandom;
      logic [DW-1:0] bd = $urandom;
      int            d1 = $urandom_range(0, 3);
      int            d2 = $urandom_range(0, 3);
      bit            mis, local_done;
      int            n  = bus_log.size();
      int            exp_stalls;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      mis        = ALIGN_CHK && (a[1:0] != 2'b00);
      local_done = mis;
      exp_stalls = local_done ? 1 : 3 + d1 + d2;
      run_access(t, a, w, d1, d2, bd, 1'($urandom));
      if (r_stalls != exp_stalls || r_bad != 0 || r_mis_other != 0 || r_mis_done != int'(mis)) bad++;
      if (r_rdata !== ((t || mis) ? '0 : bd)) bad++;
      if (local_done ? (bus_log.size() != n)
                     : (bus_log.size() != n + 1 || bus_log[n].a !== a || bus_log[n].t !== t ||
                        bus_log[n].w !== w)) bad++;
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(0, 2));
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_accesses: got %0d mismatching items required 0", bad); end
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_misaligned();
    test_spurious_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
